jump_fsm: RTL

Per-frame motion generator for the player sprite. It decodes the keyboard `keycode`, tracks the jump phase (ground, rise, fall) with gravity, and outputs signed X/Y velocities each frame. It sits directly upstream of the player position/render block, which adds `x_motion`/`y_motion` to the sprite position on every frame. The collision inputs (`on_ground`, `head_block`, `wall_left`, `wall_right`) come from that block's tile-map lookup for the current position.

---
 rtl/jump_fsm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jump_fsm.sv
// -----------------------------------------------------------------------------
// jump_fsm
// Per-frame motion generator for the player sprite. Decodes the W/A/D keys
// from the packed keyboard keycode, tracks the jump phase (ground, rise, fall)
// with a divided gravity step, and presents registered signed X/Y velocities
// that the downstream position block adds to the sprite every frame.
//
// Ports
//   Clk        : system clock (only clock)
//   Reset      : asynchronous reset, active low
//   frame_tick : one-cycle frame strobe; state advances only when high
//   keycode    : four packed key bytes (W=0x1A, A=0x04, D=0x07)
//   on_ground  : solid tile under the feet
//   head_block : solid tile above the head
//   wall_left  : solid tile to the left
//   wall_right : solid tile to the right
//   x_motion   : signed horizontal velocity, px/frame
//   y_motion   : signed vertical velocity, px/frame, positive is down
//   jump_state : 00 GROUND, 01 RISE, 10 FALL
//   jump_en    : high whenever airborne
// -----------------------------------------------------------------------------
module jump_fsm #(
   parameter int JUMP_V   = 8,
   parameter int CUT_V    = 3,
   parameter int GRAV     = 1,
   parameter int GRAV_DIV = 2,
   parameter int MAX_FALL = 6,
   parameter int WALK_V   = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic [31:0] keycode,
   input  logic        on_ground,
   input  logic        head_block,
   input  logic        wall_left,
   input  logic        wall_right,
   output logic [9:0]  x_motion,
   output logic [9:0]  y_motion,
   output logic [1:0]  jump_state,
   output logic        jump_en
);

   localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

   localparam logic signed [9:0] P_JUMP = 10'(JUMP_V);
   localparam logic signed [9:0] P_CUT  = 10'(CUT_V);
   localparam logic signed [9:0] P_GRAV = 10'(GRAV);
   localparam logic signed [9:0] P_MAXF = 10'(MAX_FALL);
   localparam logic signed [9:0] P_WALK = 10'(WALK_V);
   localparam logic [CW-1:0]     P_CLAST = CW'(GRAV_DIV - 1);

   typedef enum logic [1:0] {
      GROUND = 2'b00,
      RISE   = 2'b01,
      FALL   = 2'b10
   } state_t;

   state_t                r_state, w_state_nx;
   logic signed [9:0]     r_vy, w_vy_nx;
   logic signed [9:0]     r_vx, w_vx_nx;
   logic [CW-1:0]         r_grav_cnt, w_cnt_nx;
   logic                  r_w_prev;

   logic                  w_key_w, w_key_a, w_key_d;
   logic                  w_jump_edge;
   logic                  w_step;
   logic [CW-1:0]         w_cnt_adv;
   logic signed [9:0]     w_vy_grav;

   // Byte-wise key decode across all four keycode slots
   always_comb begin
      w_key_w = 1'b0;
      w_key_a = 1'b0;
      w_key_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (keycode[8*i +: 8] == 8'h1A) w_key_w = 1'b1;
         if (keycode[8*i +: 8] == 8'h04) w_key_a = 1'b1;
         if (keycode[8*i +: 8] == 8'h07) w_key_d = 1'b1;
      end
   end

   assign w_jump_edge = w_key_w & ~r_w_prev;
   assign w_step      = (r_grav_cnt == P_CLAST);
   assign w_cnt_adv   = w_step ? '0 : r_grav_cnt + CW'(1);
   assign w_vy_grav   = r_vy + P_GRAV;

   // Horizontal velocity: walls zero the push into them
   always_comb begin
      w_vx_nx = '0;
      if (w_key_a && !w_key_d) begin
         w_vx_nx = wall_left ? '0 : -P_WALK;
      end else if (w_key_d && !w_key_a) begin
         w_vx_nx = wall_right ? '0 : P_WALK;
      end
   end

   // Next-state and vertical velocity
   always_comb begin
      w_state_nx = r_state;
      w_vy_nx    = r_vy;
      w_cnt_nx   = r_grav_cnt;
      case (r_state)
         GROUND: begin
            w_cnt_nx = '0;
            if (!on_ground) begin
               w_state_nx = FALL;
               w_vy_nx    = P_GRAV;
            end else if (w_jump_edge) begin
               w_state_nx = RISE;
               w_vy_nx    = -P_JUMP;
            end else begin
               w_vy_nx    = '0;
            end
         end
         RISE: begin
            if (head_block) begin
               w_state_nx = FALL;
               w_vy_nx    = '0;
               w_cnt_nx   = '0;
            end else if (!w_key_w && (r_vy < -P_CUT)) begin
               // Cut tick replaces the gravity branch; the counter holds.
               w_vy_nx    = -P_CUT;
            end else begin
               w_cnt_nx = w_cnt_adv;
               if (w_step) begin
                  w_vy_nx = w_vy_grav;
                  if (!w_vy_grav[9]) begin
                     w_state_nx = FALL;
                     w_cnt_nx   = '0;
                  end
               end
            end
         end
         FALL: begin
            if (on_ground) begin
               w_state_nx = GROUND;
               w_vy_nx    = '0;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = w_cnt_adv;
               if (w_step) begin
                  w_vy_nx = (w_vy_grav > P_MAXF) ? P_MAXF : w_vy_grav;
               end
            end
         end
         default: begin
            w_state_nx = GROUND;
            w_vy_nx    = '0;
            w_cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= GROUND;
         r_vy       <= '0;
         r_vx       <= '0;
         r_grav_cnt <= '0;
         r_w_prev   <= 1'b1;
      end else if (frame_tick) begin
         r_state    <= w_state_nx;
         r_vy       <= w_vy_nx;
         r_vx       <= w_vx_nx;
         r_grav_cnt <= w_cnt_nx;
         r_w_prev   <= w_key_w;
      end
   end

   assign x_motion   = r_vx;
   assign y_motion   = r_vy;
   assign jump_state = r_state;
   assign jump_en    = (r_state != GROUND);

endmodule
